// File: rtl/dice_round_ctrl_pkg.sv
// Shared definitions for the dice blocks: state encodings, sum width and craps rule constants.
package dice_round_ctrl_pkg;

  localparam logic [2:0] S_COMEOUT = 3'd0;
  localparam logic [2:0] S_POINT   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_EVAL    = 3'd3;
  localparam logic [2:0] S_WIN     = 3'd4;
  localparam logic [2:0] S_LOSE    = 3'd5;

  localparam int SUM_W = 4;

  localparam int unsigned DIE_MIN = 1;
  localparam int unsigned DIE_MAX = 6;

  localparam logic [SUM_W-1:0] SUM_2  = 4'd2;
  localparam logic [SUM_W-1:0] SUM_3  = 4'd3;
  localparam logic [SUM_W-1:0] SUM_7  = 4'd7;
  localparam logic [SUM_W-1:0] SUM_11 = 4'd11;
  localparam logic [SUM_W-1:0] SUM_12 = 4'd12;

  function automatic logic die_ok(input int unsigned v);
    return (v >= DIE_MIN) && (v <= DIE_MAX);
  endfunction

endpackage

// File: rtl/roll_edge_sync.sv
// Two-flop synchronizer plus a third flop; emits a 1-cycle pulse on a synchronized 1->0 transition.
module roll_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic fall_pulse
);

  logic [2:0] sync_q;

  // Flops reset to 0 so a button held through reset never produces a false release.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], async_in};
  end

  assign fall_pulse = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/dice_round_ctrl.sv
// Craps round referee: waits for roll release, settles, samples both dice and applies come-out/point rules.
// Define DICE_STATS_EN to add saturating win/loss counters since reset.
module dice_round_ctrl
  import dice_round_ctrl_pkg::*;
#(
  parameter int DIE_W      = 3,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             roll,
  input  logic [DIE_W-1:0] die_a,
  input  logic [DIE_W-1:0] die_b,
  input  logic             new_game,
  output logic [SUM_W-1:0] sum_out,
  output logic [SUM_W-1:0] point,
  output logic             win,
  output logic             lose,
  output logic             busy,
  output logic             err_die,
  output logic [CNT_W-1:0] roll_cnt
`ifdef DICE_STATS_EN
  ,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] loss_cnt
`endif
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  logic             fall;
  logic [2:0]       state;
  logic [SET_W-1:0] settle_q;
  logic [DIE_W-1:0] die_a_q, die_b_q;
  logic [SUM_W-1:0] sum;
  logic             dice_ok;
  logic [2:0]       eval_state;
  logic [SUM_W-1:0] eval_point;

  roll_edge_sync u_roll_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (roll),
    .fall_pulse (fall)
  );

  assign sum     = SUM_W'(die_a_q) + SUM_W'(die_b_q);
  assign dice_ok = die_ok(32'(die_a_q)) && die_ok(32'(die_b_q));

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    eval_state = S_POINT;
    eval_point = point;
    if (point == '0) begin
      if (sum == SUM_7 || sum == SUM_11)                     eval_state = S_WIN;
      else if (sum == SUM_2 || sum == SUM_3 || sum == SUM_12) eval_state = S_LOSE;
      else                                                    eval_point = sum;
    end else if (sum == point) begin
      eval_state = S_WIN;
    end else if (sum == SUM_7) begin
      eval_state = S_LOSE;
    end
  end

  // NOTE: non-blocking assignments so every register in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_COMEOUT;
      settle_q <= '0;
      die_a_q  <= '0;
      die_b_q  <= '0;
      sum_out  <= '0;
      point    <= '0;
      err_die  <= 1'b0;
      roll_cnt <= '0;
    end else if (new_game) begin
      state    <= S_COMEOUT;
      settle_q <= '0;
      point    <= '0;
      err_die  <= 1'b0;
      roll_cnt <= '0;
    end else begin
      err_die <= 1'b0;
      case (state)
        S_COMEOUT, S_POINT: begin
          if (fall) begin
            state    <= S_SETTLE;
            settle_q <= SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            die_a_q <= die_a;
            die_b_q <= die_b;
            state   <= S_EVAL;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        S_EVAL: begin
          if (!dice_ok) begin
            // Bad sample: report it and resume waiting where the roll started.
            err_die <= 1'b1;
            state   <= (point == '0) ? S_COMEOUT : S_POINT;
          end else begin
            sum_out  <= sum;
            roll_cnt <= (roll_cnt == '1) ? roll_cnt : roll_cnt + 1'b1;
            point    <= eval_point;
            state    <= eval_state;
          end
        end
        S_WIN, S_LOSE: ;
        default: state <= S_COMEOUT;
      endcase
    end
  end

  assign win  = (state == S_WIN);
  assign lose = (state == S_LOSE);
  assign busy = (state == S_SETTLE) || (state == S_EVAL);

`ifdef DICE_STATS_EN
  logic enter_win, enter_lose;

  assign enter_win  = (state == S_EVAL) && dice_ok && (eval_state == S_WIN);
  assign enter_lose = (state == S_EVAL) && dice_ok && (eval_state == S_LOSE);

  // Lifetime statistics survive new_game; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      loss_cnt <= '0;
    end else if (!new_game) begin
      if (enter_win && win_cnt != '1)   win_cnt  <= win_cnt + 1'b1;
      if (enter_lose && loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dice_round_ctrl.sv
// Scoreboard bench for dice_round_ctrl: a craps model predicts each roll, results are compared at fixed latency.
module tb_dice_round_ctrl;

  localparam int DIE_W      = 3;
  localparam int CNT_W      = 8;
  localparam int SETTLE_CYC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             roll;
  logic [DIE_W-1:0] die_a, die_b;
  logic             new_game;
  logic [3:0]       sum_out, point;
  logic             win, lose, busy, err_die;
  logic [CNT_W-1:0] roll_cnt;
`ifdef DICE_STATS_EN
  logic [CNT_W-1:0] win_cnt, loss_cnt;
`endif

  always #5 clk = ~clk;

  dice_round_ctrl #(
    .DIE_W      (DIE_W),
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .roll     (roll),
    .die_a    (die_a),
    .die_b    (die_b),
    .new_game (new_game),
    .sum_out  (sum_out),
    .point    (point),
    .win      (win),
    .lose     (lose),
    .busy     (busy),
    .err_die  (err_die),
    .roll_cnt (roll_cnt)
`ifdef DICE_STATS_EN
    ,
    .win_cnt  (win_cnt),
    .loss_cnt (loss_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0]       sum;
    logic [3:0]       point;
    logic             win;
    logic             lose;
    logic             err;
    logic             busy_mid;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wins;
    logic [CNT_W-1:0] losses;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [3:0]       m_sum, m_point;
  logic             m_win, m_lose;
  logic [CNT_W-1:0] m_cnt, m_wins, m_losses;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_point = 0; m_win = 0; m_lose = 0; m_cnt = 0; m_wins = 0; m_losses = 0;
  endtask

  task automatic model_roll(input int a, input int b, output exp_t e);
    int s;
    e.err      = 1'b0;
    e.busy_mid = 1'b1;
    if (m_win || m_lose) begin
      e.busy_mid = 1'b0;
    end else if (a < 1 || a > 6 || b < 1 || b > 6) begin
      e.err = 1'b1;
    end else begin
      s     = a + b;
      m_sum = 4'(s);
      m_cnt = sat_inc(m_cnt);
      if (m_point == 0) begin
        if (s == 7 || s == 11)               m_win  = 1'b1;
        else if (s == 2 || s == 3 || s == 12) m_lose = 1'b1;
        else                                  m_point = 4'(s);
      end else if (s == int'(m_point)) begin
        m_win = 1'b1;
      end else if (s == 7) begin
        m_lose = 1'b1;
      end
      if (m_win)  m_wins   = sat_inc(m_wins);
      if (m_lose) m_losses = sat_inc(m_losses);
    end
    e.sum = m_sum; e.point = m_point; e.win = m_win; e.lose = m_lose;
    e.cnt = m_cnt; e.wins = m_wins; e.losses = m_losses;
  endtask

  // Press, then release at a negedge; the following posedge is the one where ff1 first sees 0.
  task automatic press_release(input int a, input int b);
    @(negedge clk);
    die_a = DIE_W'(a);
    die_b = DIE_W'(b);
    roll  = 1'b1;
    repeat (4) @(negedge clk);
    roll = 1'b0;
  endtask

  task automatic do_roll(input int a, input int b);
    exp_t e, got;
    press_release(a, b);
    model_roll(a, b, e);
    sb_q.push_back(e);
    repeat (SETTLE_CYC + 2) @(posedge clk);
    #1 check("busy_mid", busy, e.busy_mid);
    repeat (2) @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sum_out",  sum_out,  got.sum);
    check("point",    point,    got.point);
    check("win",      win,      got.win);
    check("lose",     lose,     got.lose);
    check("err_die",  err_die,  got.err);
    check("roll_cnt", roll_cnt, got.cnt);
    check("busy_end", busy,     1'b0);
`ifdef DICE_STATS_EN
    check("win_cnt",  win_cnt,  got.wins);
    check("loss_cnt", loss_cnt, got.losses);
`endif
    @(posedge clk);
    #1 check("err_pulse_end", err_die, 1'b0);
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    m_point = 0; m_win = 0; m_lose = 0; m_cnt = 0;
    check("ng_win",      win,      m_win);
    check("ng_lose",     lose,     m_lose);
    check("ng_point",    point,    m_point);
    check("ng_roll_cnt", roll_cnt, m_cnt);
    check("ng_sum_kept", sum_out,  m_sum);
    check("ng_busy",     busy,     1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sum"},   sum_out,  0);
    check({tag, "_point"}, point,    0);
    check({tag, "_win"},   win,      0);
    check({tag, "_lose"},  lose,     0);
    check({tag, "_busy"},  busy,     0);
    check({tag, "_err"},   err_die,  0);
    check({tag, "_cnt"},   roll_cnt, 0);
`ifdef DICE_STATS_EN
    check({tag, "_wcnt"},  win_cnt,  0);
    check({tag, "_lcnt"},  loss_cnt, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; roll = 1'b0; new_game = 1'b0; die_a = 3'd1; die_b = 3'd1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Natural 7 on come-out.
    do_roll(3, 4);
    pulse_new_game();

    // Snake eyes loses; a later release is ignored.
    do_roll(1, 1);
    do_roll(5, 6);
    pulse_new_game();

    // Point 6, a non-deciding 10, then making the point.
    do_roll(4, 2);
    do_roll(5, 5);
    do_roll(3, 3);
    pulse_new_game();

    // Point 8 then seven-out.
    do_roll(5, 3);
    do_roll(2, 5);
    pulse_new_game();

    // Illegal dice values leave the round untouched.
    do_roll(4, 4);
    do_roll(0, 3);
    do_roll(7, 2);
    do_roll(6, 2);
    pulse_new_game();

    // new_game while settling discards the roll.
    press_release(6, 1);
    repeat (4) @(posedge clk);
    #1 check("settle_busy", busy, 1'b1);
    pulse_new_game();
    repeat (SETTLE_CYC + 4) @(posedge clk);
    #1 check("discard_busy", busy, 1'b0);
    check("discard_cnt", roll_cnt, 0);
    check("discard_win", win, 0);
    do_roll(6, 5);
    pulse_new_game();

    // roll_cnt saturation over a long point round.
    do_roll(2, 2);
    for (int i = 0; i < 256; i++) do_roll(5, 5);
    do_roll(2, 2);
    pulse_new_game();

    // Extra wins, then rst in the middle of a roll clears everything.
    do_roll(5, 6);
    pulse_new_game();
    do_roll(3, 4);
    press_release(4, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 check_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (SETTLE_CYC + 4) @(posedge clk);
    #1 check("post_rst_busy", busy, 1'b0);
    do_roll(2, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
